cpu_axi_master: RTL and testbench
=================================

# cpu_axi_master

- AXI4 master port that turns simple core-side requests into AXI transactions on the system bus.
- Reads: one INCR burst of 1–16 words, returned to the core beat by beat.
- Writes: single-beat, with byte strobes.
- Sits between a CPU or cache miss handler and the AXI interconnect, i.e. it is the initiator that the memory-side slave wrappers respond to.

## Interface
Parameters:
- MASTER_ID, default 4'd0: value driven on ARID_M/AWID_M and expected on RID_M/BID_M.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [1:0] ignored
- req_len  in  4  read beats minus 1; ignored for writes
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- rd_valid  out  1  read beat valid
- rd_data  out  32  read beat data
- rd_last  out  1  final beat of burst
- rd_err  out  1  beat error flag
- wr_done  out  1  write-complete pulse
- wr_err  out  1  write error flag, valid with wr_done
- AR/R/AW/W/B master channels, `_M` suffix, widths from `AXI_ID_BITS`, `AXI_ADDR_BITS`, `AXI_DATA_BITS`, `AXI_LEN_BITS`, `AXI_SIZE_BITS`, `AXI_STRB_BITS`: full ARID..RREADY, AWID..BREADY sets.

## Operation
FSM states: IDLE, AR, R, WR, B.
- **IDLE:** req_ready=1. On req_valid, latch addr with [1:0] forced to 0, len, wdata, wstrb; clear beat counter; go to WR if req_write else AR.
- **AR:** ARVALID_M=1, ARADDR_M=latched addr, ARLEN_M=len, ARSIZE_M=3'b010, ARBURST_M=INCR, ARID_M=MASTER_ID. All held stable until ARREADY_M; then go to R.
- **R:** RREADY_M=1 constantly (core has no backpressure). Each RVALID_M cycle:
  - rd_valid=1, rd_data=RDATA_M, rd_last=RLAST_M (same-cycle pass-through); beat counter (5 bits, no wrap) increments.
  - rd_err=1 on a beat if RRESP_M≠OKAY or RID_M≠MASTER_ID.
  - rd_err=1 on the RLAST_M beat if the count including that beat ≠ len+1.
  - RLAST_M returns to IDLE regardless of count.
- **WR:** AWVALID_M and WVALID_M both asserted on entry.
  - AWADDR_M=latched addr, AWLEN_M=0, AWSIZE_M=3'b010, AWBURST_M=INCR, WDATA_M/WSTRB_M latched, WLAST_M=1.
  - Flags aw_done/w_done set on their handshakes; each VALID drops on its own handshake.
  - Go to B once both are done, whether they complete in the same cycle or in either order.
- **B:** BREADY_M=1. On BVALID_M: wr_done=1 for one cycle, wr_err=(BRESP_M≠OKAY)|(BID_M≠MASTER_ID); go to IDLE.
- Core outputs rd_*, wr_* are 0 outside their valid cycles.
- Unused slave-driven inputs are ignored outside their states.

## Timing
- Reset (rst low, async): state IDLE, counters and flags cleared, all *VALID_M/*READY_M=0, req_ready=1, rd_*=0, wr_*=0. Any outstanding transaction is abandoned immediately.
- Request accepted in cycle 0 → ARVALID_M/AWVALID_M high in cycle 1; they come from registered state, never combinationally from req_valid.
- VALID never drops before its handshake; address/data stable while VALID high.
- Read data latency to core: 0 cycles after R handshake.
- wr_done: same cycle as B handshake.
- Back-to-back: next request is accepted at the earliest in the cycle after returning to IDLE, which means one IDLE cycle between transactions.
- 16-beat burst (len=15): counter reaches 16 without overflow.

## Structure
- AXI widths and `AXI_RESP_*`/`AXI_BURST_INC` constants come from the shared AXI define header.
- FSM enum and latched-request struct are local to the module.
- No sub-module: one always_comb (next state + outputs) and one always_ff with async active-low reset.

## Test plan
- Single read, addr=0x0000_1003, len=0, slave returns 0xDEADBEEF OKAY with RLAST → ARADDR_M=0x0000_1000, ARLEN_M=0; rd_valid 1 cycle, rd_data=0xDEADBEEF, rd_last=1, rd_err=0.
- Burst read len=3, slave inserts RVALID gaps and delays ARREADY by 3 cycles → ARVALID_M held 4 cycles with stable fields; 4 rd_valid pulses in order; rd_last only on 4th.
- Read len=3, slave asserts RLAST on beat 2 with SLVERR on beat 1 → rd_err on beats 1 and 2; return to IDLE; req_ready=1 next cycle.
- Write 0x12345678, wstrb=4'b0011; slave accepts W 2 cycles before AW, then a second write with both accepted in the same cycle → WLAST_M=1, AWLEN_M=0, each VALID drops on its own handshake; one wr_done per write, wr_err=0.
- Write with BRESP=DECERR → wr_done with wr_err=1.
- rst low mid-burst after beat 2 of len=7 → all VALID/READY 0 in the same cycle; after release a new read issues correctly with counter restarted.

Source files
------------

// File: rtl/cpu_axi_master_pkg.sv
// cpu_axi_master_pkg: AXI bus widths and protocol encodings shared by the
// core-side AXI master and its environment.
package cpu_axi_master_pkg;
    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0]               AXI_BURST_INC = 2'b01;
    localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE_WORD = 3'b010;
endpackage

// File: rtl/cpu_axi_master.sv
// cpu_axi_master: turns core requests into one INCR read burst (1-16 beats)
// or a single-beat strobed write on an AXI master port.
module cpu_axi_master
    import cpu_axi_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [3:0]               req_len,
    input  logic [31:0]              req_wdata,
    input  logic [3:0]               req_wstrb,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic                     rd_last,
    output logic                     rd_err,
    output logic                     wr_done,
    output logic                     wr_err,
    output logic [AXI_ID_BITS-1:0]   ARID_M,
    output logic [AXI_ADDR_BITS-1:0] ARADDR_M,
    output logic [AXI_LEN_BITS-1:0]  ARLEN_M,
    output logic [AXI_SIZE_BITS-1:0] ARSIZE_M,
    output logic [1:0]               ARBURST_M,
    output logic                     ARVALID_M,
    input  logic                     ARREADY_M,
    input  logic [AXI_ID_BITS-1:0]   RID_M,
    input  logic [AXI_DATA_BITS-1:0] RDATA_M,
    input  logic [1:0]               RRESP_M,
    input  logic                     RLAST_M,
    input  logic                     RVALID_M,
    output logic                     RREADY_M,
    output logic [AXI_ID_BITS-1:0]   AWID_M,
    output logic [AXI_ADDR_BITS-1:0] AWADDR_M,
    output logic [AXI_LEN_BITS-1:0]  AWLEN_M,
    output logic [AXI_SIZE_BITS-1:0] AWSIZE_M,
    output logic [1:0]               AWBURST_M,
    output logic                     AWVALID_M,
    input  logic                     AWREADY_M,
    output logic [AXI_DATA_BITS-1:0] WDATA_M,
    output logic [AXI_STRB_BITS-1:0] WSTRB_M,
    output logic                     WLAST_M,
    output logic                     WVALID_M,
    input  logic                     WREADY_M,
    input  logic [AXI_ID_BITS-1:0]   BID_M,
    input  logic [1:0]               BRESP_M,
    input  logic                     BVALID_M,
    output logic                     BREADY_M
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_e     state_q, state_d;
    req_t       req_q, req_d;
    logic [4:0] cnt_q, cnt_d, cnt_inc;
    logic       aw_done_q, aw_done_d, w_done_q, w_done_d;

    // Address/data fields come straight from the latched request so they stay
    // stable for as long as the matching VALID is high.
    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = req_q.addr;
    assign ARLEN_M   = req_q.len;
    assign ARSIZE_M  = AXI_SIZE_WORD;
    assign ARBURST_M = AXI_BURST_INC;
    assign AWID_M    = MASTER_ID;
    assign AWADDR_M  = req_q.addr;
    assign AWLEN_M   = '0;
    assign AWSIZE_M  = AXI_SIZE_WORD;
    assign AWBURST_M = AXI_BURST_INC;
    assign WDATA_M   = req_q.wdata;
    assign WSTRB_M   = req_q.wstrb;
    assign WLAST_M   = 1'b1;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        req_ready = 1'b0;
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        AWVALID_M = 1'b0;
        WVALID_M  = 1'b0;
        BREADY_M  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        rd_err    = 1'b0;
        wr_done   = 1'b0;
        wr_err    = 1'b0;
        // Saturate so an overlong slave burst cannot wrap back to a valid count.
        cnt_inc   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_d     = '{addr: {req_addr[31:2], 2'b00}, len: req_len,
                                  wdata: req_wdata, wstrb: req_wstrb};
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? S_WR : S_AR;
                end
            end
            S_AR: begin
                ARVALID_M = 1'b1;
                state_d   = ARREADY_M ? S_R : S_AR;
            end
            S_R: begin
                RREADY_M = 1'b1;
                if (RVALID_M) begin
                    rd_valid = 1'b1;
                    rd_data  = RDATA_M;
                    rd_last  = RLAST_M;
                    cnt_d    = cnt_inc;
                    rd_err   = (RRESP_M != AXI_RESP_OKAY) || (RID_M != MASTER_ID) ||
                               (RLAST_M && cnt_inc != {1'b0, req_q.len} + 5'd1);
                    state_d  = RLAST_M ? S_IDLE : S_R;
                end
            end
            S_WR: begin
                AWVALID_M = !aw_done_q;
                WVALID_M  = !w_done_q;
                aw_done_d = aw_done_q || AWREADY_M;
                w_done_d  = w_done_q || WREADY_M;
                state_d   = (aw_done_d && w_done_d) ? S_B : S_WR;
            end
            S_B: begin
                BREADY_M = 1'b1;
                if (BVALID_M) begin
                    wr_done = 1'b1;
                    wr_err  = (BRESP_M != AXI_RESP_OKAY) || (BID_M != MASTER_ID);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_cpu_axi_master.sv
// tb_cpu_axi_master: randomized AXI slave stimulus checked against expected
// core-side and bus-side behaviour derived from the transaction rules.
module tb_cpu_axi_master;
    import cpu_axi_master_pkg::*;

    localparam logic [3:0] MID = 4'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_len, req_wstrb;
    logic        rd_valid, rd_last, rd_err, wr_done, wr_err;
    logic [31:0] rd_data;
    logic [3:0]  ARID_M, RID_M, AWID_M, BID_M;
    logic [31:0] ARADDR_M, RDATA_M, AWADDR_M, WDATA_M;
    logic [3:0]  ARLEN_M, AWLEN_M, WSTRB_M;
    logic [2:0]  ARSIZE_M, AWSIZE_M;
    logic [1:0]  ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
    logic        ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
    logic        AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_axi_master #(.MASTER_ID(MID)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
        .wr_done(wr_done), .wr_err(wr_err),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic send_req(input bit wr, input logic [31:0] a, input logic [3:0] l,
                            input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready got %b exp 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_len = 4'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] l, input int nb,
                           input logic [15:0] errm, input logic [15:0] idm, input int ard,
                           input bit gaps, input logic [31:0] fd);
        logic [31:0] d;
        bit e;
        int g;
        send_req(1'b0, a, l, 32'h0, 4'h0);
        for (int c = 0; c <= ard; c++) begin
            ARREADY_M = (c == ard);
            @(negedge clk);
            checks++;
            if ({ARVALID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARID_M, RREADY_M} !==
                {1'b1, a & ~32'h3, l, 3'b010, 2'b01, MID, 1'b0}) begin
                errors++;
                $display("FAIL ar_hold cyc %0d got v=%b addr=%h len=%h size=%h burst=%h id=%h exp addr=%h len=%h",
                         c, ARVALID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARID_M, a & ~32'h3, l);
            end
            @(posedge clk); #1;
        end
        ARREADY_M = 1'b0;
        for (int i = 0; i < nb; i++) begin
            g = 0;
            while (gaps && g < 3 && $urandom_range(0, 2) == 0) begin
                g++;
                RVALID_M = 1'b0; RDATA_M = $urandom; RLAST_M = 1'($urandom); RRESP_M = AXI_RESP_SLVERR;
                @(negedge clk);
                checks++;
                if ({RREADY_M, ARVALID_M, rd_valid, rd_last, rd_err, rd_data} !== {5'b10000, 32'h0}) begin
                    errors++;
                    $display("FAIL r_gap got rready=%b arvalid=%b rd_valid=%b last=%b err=%b data=%h exp 1/0/0/0/0/0",
                             RREADY_M, ARVALID_M, rd_valid, rd_last, rd_err, rd_data);
                end
                @(posedge clk); #1;
            end
            d = (fd != 0) ? fd + i : $urandom;
            e = errm[i] | idm[i] | ((i == nb - 1) && (nb != int'(l) + 1));
            RVALID_M = 1'b1; RDATA_M = d; RLAST_M = (i == nb - 1);
            RRESP_M = errm[i] ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            RID_M = idm[i] ? MID ^ 4'h5 : MID;
            @(negedge clk);
            checks++;
            if ({rd_valid, rd_data, rd_last, rd_err, RREADY_M, ARVALID_M} !==
                {1'b1, d, (i == nb - 1), e, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL r_beat %0d got valid=%b data=%h last=%b err=%b rready=%b exp 1 %h %b %b 1",
                         i, rd_valid, rd_data, rd_last, rd_err, RREADY_M, d, (i == nb - 1), e);
            end
            @(posedge clk); #1;
        end
        RVALID_M = 1'b0; RLAST_M = 1'b0; RRESP_M = AXI_RESP_OKAY; RID_M = MID;
        @(negedge clk);
        checks++;
        if ({req_ready, RREADY_M, rd_valid} !== 3'b100) begin
            errors++;
            $display("FAIL r_end got req_ready=%b rready=%b rd_valid=%b exp 1 0 0", req_ready, RREADY_M, rd_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input logic [1:0] bresp,
                            input bit badid, input int bd);
        bit aws = 0;
        bit ws = 0;
        bit e;
        send_req(1'b1, a, 4'($urandom), d, s);
        for (int c = 0; c < 40 && !(aws && ws); c++) begin
            AWREADY_M = !aws && c >= awd;
            WREADY_M  = !ws && c >= wd;
            @(negedge clk);
            checks++;
            if ({AWVALID_M, WVALID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWID_M, WDATA_M, WSTRB_M, WLAST_M, BREADY_M} !==
                {!aws, !ws, a & ~32'h3, 4'h0, 3'b010, 2'b01, MID, d, s, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL w_phase cyc %0d got awv=%b wv=%b addr=%h len=%h data=%h strb=%h wlast=%b exp awv=%b wv=%b addr=%h data=%h strb=%h",
                         c, AWVALID_M, WVALID_M, AWADDR_M, AWLEN_M, WDATA_M, WSTRB_M, WLAST_M,
                         !aws, !ws, a & ~32'h3, d, s);
            end
            @(posedge clk); #1;
            if (AWREADY_M) aws = 1;
            if (WREADY_M) ws = 1;
        end
        AWREADY_M = 1'b0; WREADY_M = 1'b0;
        e = (bresp != AXI_RESP_OKAY) | badid;
        for (int c = 0; c <= bd; c++) begin
            BVALID_M = (c == bd);
            BRESP_M = (c == bd) ? bresp : 2'($urandom);
            BID_M = badid ? MID ^ 4'h9 : MID;
            @(negedge clk);
            checks++;
            if ({BREADY_M, AWVALID_M, WVALID_M, wr_done, wr_err, req_ready} !==
                {1'b1, 1'b0, 1'b0, (c == bd), (c == bd) && e, 1'b0}) begin
                errors++;
                $display("FAIL b_phase cyc %0d got bready=%b awv=%b wv=%b done=%b err=%b ready=%b exp done=%b err=%b",
                         c, BREADY_M, AWVALID_M, WVALID_M, wr_done, wr_err, req_ready, (c == bd), (c == bd) && e);
            end
            @(posedge clk); #1;
        end
        BVALID_M = 1'b0; BID_M = MID; BRESP_M = AXI_RESP_OKAY;
        @(negedge clk);
        checks++;
        if ({req_ready, wr_done, wr_err, BREADY_M} !== 4'b1000) begin
            errors++;
            $display("FAIL w_end got ready=%b done=%b err=%b bready=%b exp 1 0 0 0", req_ready, wr_done, wr_err, BREADY_M);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_wdata = 0; req_wstrb = 0;
        ARREADY_M = 0; RID_M = MID; RDATA_M = 0; RRESP_M = 0; RLAST_M = 0; RVALID_M = 0;
        AWREADY_M = 0; WREADY_M = 0; BID_M = MID; BRESP_M = 0; BVALID_M = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req_ready, ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, rd_valid, rd_last, rd_err, wr_done, wr_err}
                !== 11'b100_0000_0000) begin
                errors++;
                $display("FAIL reset_state %0d got %b exp 10000000000", k,
                         {req_ready, ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, rd_valid, rd_last, rd_err, wr_done, wr_err});
            end
            rst = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_read();
        do_read(32'h0000_1003, 4'd0, 1, 16'h0, 16'h0, 0, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_burst_read();
        do_read(32'h0000_2000, 4'd3, 4, 16'h0, 16'h0, 3, 1'b1, 32'h0);
        do_read(32'h0000_3F02, 4'd15, 16, 16'h0, 16'h0, 1, 1'b1, 32'h0);
    endtask

    task automatic test_read_err();
        do_read(32'h0000_4004, 4'd3, 2, 16'h0001, 16'h0, 0, 1'b0, 32'h0);
        do_read(32'h0000_4008, 4'd1, 2, 16'h0, 16'h0002, 0, 1'b0, 32'h0);
    endtask

    task automatic test_write();
        do_write(32'h0000_5001, 32'h12345678, 4'b0011, 2, 0, AXI_RESP_OKAY, 1'b0, 1);
        do_write(32'h0000_5004, 32'hCAFEF00D, 4'b1111, 0, 0, AXI_RESP_OKAY, 1'b0, 0);
        do_write(32'h0000_5008, 32'hA5A5A5A5, 4'b1000, 0, 3, AXI_RESP_OKAY, 1'b0, 2);
    endtask

    task automatic test_write_err();
        do_write(32'h0000_6000, 32'h0BADF00D, 4'b0100, 1, 1, AXI_RESP_DECERR, 1'b0, 0);
        do_write(32'h0000_6004, 32'h11111111, 4'b0001, 0, 0, AXI_RESP_OKAY, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d = $urandom;
        send_req(1'b1, 32'h0000_7000, 4'h0, 32'h55AA55AA, 4'hF);
        AWREADY_M = 1'b1; WREADY_M = 1'b1;
        @(posedge clk); #1;
        AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b1; BRESP_M = AXI_RESP_OKAY;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_7102; req_len = 4'd0;
        @(negedge clk);
        checks++;
        if ({wr_done, wr_err, req_ready} !== 3'b100) begin
            errors++; $display("FAIL b2b_bdone got done=%b err=%b ready=%b exp 1 0 0", wr_done, wr_err, req_ready);
        end
        @(posedge clk); #1;
        BVALID_M = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, ARVALID_M} !== 2'b10) begin
            errors++; $display("FAIL b2b_idle got ready=%b arvalid=%b exp 1 0", req_ready, ARVALID_M);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; ARREADY_M = 1'b1;
        @(negedge clk);
        checks++;
        if ({ARVALID_M, ARADDR_M, ARLEN_M} !== {1'b1, 32'h0000_7100, 4'd0}) begin
            errors++; $display("FAIL b2b_ar got v=%b addr=%h len=%h exp 1 00007100 0", ARVALID_M, ARADDR_M, ARLEN_M);
        end
        @(posedge clk); #1;
        ARREADY_M = 1'b0; RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = d;
        @(negedge clk);
        checks++;
        if ({rd_valid, rd_data, rd_last, rd_err} !== {1'b1, d, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_r got v=%b data=%h last=%b err=%b exp 1 %h 1 0", rd_valid, rd_data, rd_last, rd_err, d);
        end
        @(posedge clk); #1;
        RVALID_M = 1'b0; RLAST_M = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        send_req(1'b0, 32'h0000_8000, 4'd7, 32'h0, 4'h0);
        ARREADY_M = 1'b1;
        @(posedge clk); #1;
        ARREADY_M = 1'b0;
        for (int i = 0; i < 2; i++) begin
            RVALID_M = 1'b1; RDATA_M = $urandom; RLAST_M = 1'b0;
            @(negedge clk);
            checks++;
            if ({rd_valid, rd_last, rd_err} !== 3'b100) begin
                errors++; $display("FAIL mid_beat %0d got v=%b last=%b err=%b exp 1 0 0", i, rd_valid, rd_last, rd_err);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, rd_valid, req_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL mid_reset got %b exp 0000001", {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, rd_valid, req_ready});
        end
        @(posedge clk); #1;
        RVALID_M = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        do_read(32'h0000_9001, 4'd2, 3, 16'h0, 16'h0, 1, 1'b1, 32'h0);
    endtask

    task automatic test_random();
        logic [3:0] l;
        int nb;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                l = 4'($urandom);
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : int'(l) + 1;
                do_read($urandom, l, nb,
                        ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0,
                        ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0,
                        $urandom_range(0, 3), 1'b1, 32'h0);
            end else begin
                do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         2'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_read();
        test_read_err();
        test_write();
        test_write_err();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
